matrix_stream_tx: RTL and testbench

//  Serializer on the output side of the sequential matrix multiplier. Captures a flat
//  M*N*N-bit matrix bus (element (i,j) at bits M*(N*i+j+1)-1 : M*(N*i+j)) on a load

---
 rtl/matrix_stream_tx_pkg.sv | 24 ++
 rtl/matrix_index_counter.sv | 70 +++++++
 rtl/matrix_stream_tx.sv | 91 +++++++++
 tb/tb_matrix_stream_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_tx_pkg.sv
// Shared definitions for the matrix stream serializer.
//   state_e : FSM state encoding (2 bits) used by the top-level transfer controller.
//   log2    : bit count of a value (log2(3) = 2, log2(4) = 3); sizes the row/col indices.
package matrix_stream_tx_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned n;
    int unsigned x;
    n = 0;
    x = v;
    while (x != 0) begin
      n++;
      x = x >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker for the matrix stream serializer.
// Build option: MATRIX_STREAM_COLMAJOR_EN selects column-major order; default is row-major.
// Ports:
//   clk, rst : clock, synchronous active-high reset (indices to 0)
//   clear    : restart at element (0,0)
//   step     : advance to the next element in stream order
//   row, col : current element coordinates
//   last     : current element is (N-1,N-1)
module matrix_index_counter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  localparam logic [IW-1:0] IdxMax = IW'(N - 1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == IdxMax) && (col_q == IdxMax);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (step) begin
      if (last) begin
        // Wrap explicitly so indices never reach N.
        row_d = '0;
        col_d = '0;
`ifdef MATRIX_STREAM_COLMAJOR_EN
      end else if (row_q == IdxMax) begin
        row_d = '0;
        col_d = col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      end else if (col_q == IdxMax) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/matrix_stream_tx.sv
// Serializer for the matrix multiplier result bus: captures an N x N matrix of M-bit
// elements on load and streams one element per accepted valid/ready beat.
// Build option: MATRIX_STREAM_COLMAJOR_EN (column-major order, in matrix_index_counter).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load, m_in          : capture strobe (IDLE only) and flat matrix, elem (i,j) at M*(N*i+j)
//   busy                : transfer in progress (SEND or DONE)
//   out_valid/out_ready : element handshake
//   out_data/row/col    : current element and its true coordinates
//   done                : one-cycle pulse after the final element is accepted
module matrix_stream_tx
  import matrix_stream_tx_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned M    = 32,
  localparam int unsigned IW  = log2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [M*N*N-1:0] m_in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    out_data,
  output logic [IW-1:0]   out_row,
  output logic [IW-1:0]   out_col,
  output logic            done
);

  state_e state_q, state_d;
  logic [M*N*N-1:0] cap_q;
  logic capture;
  logic beat;
  logic last;
  logic [31:0] elem_idx;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          capture = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        beat = out_ready;
        if (out_ready && last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) cap_q <= m_in;
    end
  end

  matrix_index_counter #(
    .N  (N),
    .IW (IW)
  ) u_index (
    .clk   (clk),
    .rst   (rst),
    .clear (capture),
    .step  (beat),
    .row   (out_row),
    .col   (out_col),
    .last  (last)
  );

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StSend);
  assign done      = (state_q == StDone);

  // Indices only move on a beat, so the selected slice is stable while stalled.
  always_comb begin
    elem_idx = N * 32'(out_row) + 32'(out_col);
    out_data = M'(cap_q >> (M * elem_idx));
  end

endmodule

// File: tb/tb_matrix_stream_tx.sv
module tb_matrix_stream_tx;

`ifdef MATRIX_STREAM_COLMAJOR_EN
  localparam bit ColMaj = 1'b1;
`else
  localparam bit ColMaj = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
  } ent_t;

  typedef struct {
    logic rst, load, rdy;
    logic busy, valid, done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // DUT a: N=3, M=32
  logic [287:0] a_m = '0;
  logic a_load = 1'b0, a_ready = 1'b0;
  logic a_busy, a_valid, a_done;
  logic [31:0] a_data;
  logic [1:0] a_row, a_col;

  // DUT b: N=4, M=8
  logic [127:0] b_m = '0;
  logic b_load = 1'b0, b_ready = 1'b0;
  logic b_busy, b_valid, b_done;
  logic [7:0] b_data;
  logic [2:0] b_row, b_col;

  int checks = 0;
  int errors = 0;

  ent_t qa[$], qb[$];
  ent_t ea, eb;
  bit a_done_exp = 0, b_done_exp = 0;
  bit a_stall = 0, b_stall = 0;
  logic [36:0] a_hold;
  logic [14:0] b_hold;

  matrix_stream_tx #(.N(3), .M(32)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .m_in(a_m), .busy(a_busy), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .out_row(a_row), .out_col(a_col), .done(a_done)
  );

  matrix_stream_tx #(.N(4), .M(8)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .m_in(b_m), .busy(b_busy), .out_valid(b_valid),
    .out_ready(b_ready), .out_data(b_data), .out_row(b_row), .out_col(b_col), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for one transfer, in the build's traversal order.
  task automatic push(input int which, input logic [287:0] mat);
    int n, w, r, c;
    logic [287:0] tmp;
    ent_t e;
    n = (which == 0) ? 3 : 4;
    w = (which == 0) ? 32 : 8;
    for (int o = 0; o < n; o++) begin
      for (int in = 0; in < n; in++) begin
        r = ColMaj ? in : o;
        c = ColMaj ? o : in;
        tmp = mat >> (w * (n * r + c));
        e.data = (w == 8) ? {24'h0, tmp[7:0]} : tmp[31:0];
        e.row = 3'(r);
        e.col = 3'(c);
        if (which == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0,..., 2: random
  task automatic drain(input int which, input string name, input int mode);
    int c;
    logic r;
    c = 0;
    while (((which == 0) ? qa.size() : qb.size()) != 0 && c < 300) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 3) == 0) : 1'($urandom_range(0, 1));
      if (which == 0) a_ready = r;
      else b_ready = r;
      step();
      c++;
    end
    a_ready = 1'b1;
    if (which != 0) b_ready = 1'b1;
    checks++;
    if (c == 300) begin
      errors++;
      $display("FAIL %s drain timeout left=%0d exp=0", name, (which == 0) ? qa.size() : qb.size());
    end
    repeat (2) step();
    check({name, "_idle_after"}, (which == 0) ? a_busy : b_busy, 1'b0);
  endtask

  // Scoreboard / protocol monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      a_done_exp = 0;
      a_stall = 0;
    end else begin
      check("a_done", a_done, a_done_exp);
      a_done_exp = 0;
      if (a_stall) check("a_stall_hold", {a_valid, a_data, a_row, a_col}, a_hold);
      a_stall = 0;
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_beat got=%0h exp=none", a_data);
        end else begin
          ea = qa.pop_front();
          check("a_beat", {a_data, 1'b0, a_row, 1'b0, a_col}, ea);
          a_done_exp = (qa.size() == 0);
        end
      end else if (a_valid) begin
        a_stall = 1;
        a_hold = {1'b1, a_data, a_row, a_col};
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      b_done_exp = 0;
      b_stall = 0;
    end else begin
      check("b_done", b_done, b_done_exp);
      b_done_exp = 0;
      if (b_stall) check("b_stall_hold", {b_valid, b_data, b_row, b_col}, b_hold);
      b_stall = 0;
      if (b_valid && b_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_beat got=%0h exp=none", b_data);
        end else begin
          eb = qb.pop_front();
          check("b_beat", {24'h0, b_data, b_row, b_col}, eb);
          b_done_exp = (qb.size() == 0);
        end
      end else if (b_valid) begin
        b_stall = 1;
        b_hold = {1'b1, b_data, b_row, b_col};
      end
    end
  end

  logic [287:0] ma, ma2, mb1, mb2;
  vec_t vt[$];

  initial begin
    ma = '0; ma2 = '0; mb1 = '0; mb2 = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ma[32*(3*i+j) +: 32]  = 32'(10 * i + j);
        ma2[32*(3*i+j) +: 32] = 32'hC0DE_0000 + 32'(16 * i + j);
      end
    end
    for (int k = 0; k < 16; k++) begin
      mb1[8*k +: 8] = 8'hFF;
      mb2[8*k +: 8] = (k % 2 == 0) ? 8'hA5 : 8'h5A;
    end

    // Control-path vectors for reset and a full-speed row-major transfer.
    vt.push_back('{rst: 1, load: 0, rdy: 0, busy: 0, valid: 0, done: 0});
    vt.push_back('{rst: 0, load: 0, rdy: 1, busy: 0, valid: 0, done: 0});
    vt.push_back('{rst: 0, load: 1, rdy: 1, busy: 1, valid: 1, done: 0});
    for (int k = 0; k < 8; k++)
      vt.push_back('{rst: 0, load: 0, rdy: 1, busy: 1, valid: 1, done: 0});
    vt.push_back('{rst: 0, load: 0, rdy: 1, busy: 1, valid: 0, done: 1});
    vt.push_back('{rst: 0, load: 0, rdy: 1, busy: 0, valid: 0, done: 0});

    a_m = ma;
    step();
    foreach (vt[k]) begin
      rst = vt[k].rst;
      a_load = vt[k].load;
      a_ready = vt[k].rdy;
      if (vt[k].load) push(0, ma);
      step();
      check($sformatf("vec%0d_ctl", k), {a_busy, a_valid, a_done},
            {vt[k].busy, vt[k].valid, vt[k].done});
      if (k == 0) begin
        check("reset_idx_data", {a_row, a_col, a_data}, 36'h0);
        check("reset_b_ctl", {b_busy, b_valid, b_done, b_row, b_col, b_data}, 17'h0);
      end
    end
    a_load = 1'b0;
    check("t1_queue_empty", 32'(qa.size()), 32'd0);

    // Backpressure: same matrix with ready pattern 1,0,0.
    push(0, ma);
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    drain(0, "t2", 1);

    // Load during beat 4 with a new matrix is ignored; next idle load captures it.
    push(0, ma);
    a_ready = 1'b1;
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    repeat (3) step();
    a_m = ma2;
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    drain(0, "t3a", 0);
    push(0, ma2);
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    drain(0, "t3b", 2);

    // Reset after beat 5 aborts the transfer; the next load restarts at (0,0).
    a_m = ma;
    push(0, ma);
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_after_rst", {a_valid, a_busy, a_done, a_row, a_col, a_data}, 39'h0);
    step();
    check("t4_no_done", {a_valid, a_busy, a_done}, 3'b000);
    push(0, ma);
    a_load = 1'b1;
    step();
    a_load = 1'b0;
    drain(0, "t4", 0);

    // N=4, M=8: all-ones then alternating A5/5A, the second under random backpressure.
    b_m = mb1[127:0];
    push(1, mb1);
    b_ready = 1'b1;
    b_load = 1'b1;
    step();
    b_load = 1'b0;
    drain(1, "t6a", 0);
    b_m = mb2[127:0];
    push(1, mb2);
    b_load = 1'b1;
    step();
    b_load = 1'b0;
    drain(1, "t6b", 2);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
